// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall/flush sequencer (slave).
// Carries hazard observations one way and stage enables, flushes and perf counts the other.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CntWidth = 32
);
    logic [4:0]          id_rs1n;
    logic [4:0]          id_rs2n;
    logic                id_uses_rs1;
    logic                id_uses_rs2;
    logic [4:0]          ex_rdn;
    logic                ex_is_load;
    logic                ex_branch_taken;
    logic                mem_busy;
    logic                clr_counts;

    logic                pc_en;
    logic                pc_redirect;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_en;
    logic                idex_flush;
    logic                exmem_en;
    logic [1:0]          state_o;
    logic [CntWidth-1:0] stall_count;
    logic [CntWidth-1:0] flush_count;

    modport master (
        output id_rs1n, id_rs2n, id_uses_rs1, id_uses_rs2, ex_rdn, ex_is_load,
               ex_branch_taken, mem_busy, clr_counts,
        input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, state_o, stall_count, flush_count
    );

    modport slave (
        input  id_rs1n, id_rs2n, id_uses_rs1, id_uses_rs2, ex_rdn, ex_is_load,
               ex_branch_taken, mem_busy, clr_counts,
        output pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, state_o, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, taken-branch refill flushes, memory freezes.
// Control outputs are same-cycle combinational; FSM, refill counter and saturating perf counters are registered.
module pipeline_hazard_ctrl #(
    parameter int unsigned FlushCycles = 1,
    parameter int unsigned CntWidth    = 32
) (
    input logic                   clk,
    input logic                   rstn,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned CW = (FlushCycles > 2) ? $clog2(FlushCycles - 1) : 1;
    localparam logic [CW-1:0] CntInit = CW'((FlushCycles > 1) ? (FlushCycles - 2) : 0);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_FLUSH    = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CntWidth-1:0] stall_count_q, stall_count_d;
    logic [CntWidth-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;

    // x0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign load_use = bus.ex_is_load && (bus.ex_rdn != 5'd0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1n == bus.ex_rdn)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2n == bus.ex_rdn)));

    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (rstn) begin
            case (state_q)
                S_FLUSH: begin
                    // A memory freeze holds the refill window where it is.
                    if (!bus.mem_busy) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = S_RUN;
                        end else begin
                            cnt_d = cnt_q - CW'(1);
                        end
                    end
                end
                default: begin
                    // MEM_WAIT resumes with RUN rules on its first free cycle.
                    if (bus.mem_busy) begin
                        state_d = S_MEM_WAIT;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        state_d  = S_RUN;
                        if (bus.ex_branch_taken) begin
                            pc_redirect = 1'b1;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            if (FlushCycles > 1) begin
                                state_d = S_FLUSH;
                                cnt_d   = CntInit;
                            end
                        end else if (load_use) begin
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bus.clr_counts) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (!pc_en && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CntWidth'(1);
            end
            if (pc_redirect && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.pc_redirect = pc_redirect;
    assign bus.ifid_en     = ifid_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_en     = idex_en;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_en    = exmem_en;
    assign bus.state_o     = rstn ? state_q : 2'd0;
    assign bus.stall_count = stall_count_q;
    assign bus.flush_count = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FlushCycles=3 and 4-bit counters.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    pipeline_hazard_ctrl_if #(.CntWidth(4)) hif ();

    pipeline_hazard_ctrl #(.FlushCycles(3), .CntWidth(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hif.id_rs1n = 5'd0; hif.id_rs2n = 5'd0;
        hif.id_uses_rs1 = 1'b0; hif.id_uses_rs2 = 1'b0;
        hif.ex_rdn = 5'd0; hif.ex_is_load = 1'b0;
        hif.ex_branch_taken = 1'b0; hif.mem_busy = 1'b0; hif.clr_counts = 1'b0;
    endtask

    task automatic set_load_use();
        hif.ex_is_load = 1'b1; hif.ex_rdn = 5'd5;
        hif.id_rs2n = 5'd5; hif.id_uses_rs2 = 1'b1;
    endtask

    task automatic clear_counts();
        hif.clr_counts = 1'b1;
        tick();
        hif.clr_counts = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        hif.ex_branch_taken = 1'b1;
        #1;
        checks++; if (hif.pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en: got %b want 0", hif.pc_en); end
        checks++; if (hif.pc_redirect !== 1'b0 || hif.ifid_flush !== 1'b0 || hif.idex_flush !== 1'b0) begin
            errors++; $display("FAIL rst_redirect_flush: got %b%b%b want 000", hif.pc_redirect, hif.ifid_flush, hif.idex_flush); end
        checks++; if (hif.state_o !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", hif.state_o); end
        tick();
        tick();
        rstn = 1'b1;
        idle();
        #1;
        checks++; if ({hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en} !== 4'b1111) begin
            errors++; $display("FAIL rst_default_en: got %b want 1111", {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en}); end
        checks++; if (hif.stall_count !== 4'd0 || hif.flush_count !== 4'd0) begin
            errors++; $display("FAIL rst_counts: got %0d/%0d want 0/0", hif.stall_count, hif.flush_count); end
        tick();
    endtask

    task automatic test_load_use();
        clear_counts();
        set_load_use();
        #1;
        checks++; if ({hif.pc_en, hif.ifid_en, hif.idex_en, hif.idex_flush, hif.exmem_en} !== 5'b00111) begin
            errors++; $display("FAIL lu_ctrl: got %b want 00111", {hif.pc_en, hif.ifid_en, hif.idex_en, hif.idex_flush, hif.exmem_en}); end
        tick();
        idle();
        #1;
        checks++; if (hif.stall_count !== 4'd1) begin errors++; $display("FAIL lu_stall_count: got %0d want 1", hif.stall_count); end
        checks++; if (hif.pc_en !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", hif.pc_en); end
        // x0 destination never hazards
        hif.ex_is_load = 1'b1; hif.ex_rdn = 5'd0; hif.id_rs2n = 5'd0; hif.id_uses_rs2 = 1'b1;
        #1;
        checks++; if (hif.pc_en !== 1'b1 || hif.idex_flush !== 1'b0) begin
            errors++; $display("FAIL lu_x0: got pc_en=%b idex_flush=%b want 1/0", hif.pc_en, hif.idex_flush); end
        // matching rs1 index that the instruction does not read
        hif.ex_rdn = 5'd7; hif.id_rs1n = 5'd7; hif.id_uses_rs1 = 1'b0; hif.id_rs2n = 5'd3;
        #1;
        checks++; if (hif.pc_en !== 1'b1) begin errors++; $display("FAIL lu_unused_rs1: got %b want 1", hif.pc_en); end
        hif.id_uses_rs1 = 1'b1;
        #1;
        checks++; if (hif.pc_en !== 1'b0 || hif.idex_flush !== 1'b1) begin
            errors++; $display("FAIL lu_rs1: got pc_en=%b idex_flush=%b want 0/1", hif.pc_en, hif.idex_flush); end
        tick();
        idle();
        #1;
        checks++; if (hif.stall_count !== 4'd2) begin errors++; $display("FAIL lu_stall_count2: got %0d want 2", hif.stall_count); end
        tick();
    endtask

    task automatic test_branch();
        clear_counts();
        hif.ex_branch_taken = 1'b1;
        #1;
        checks++; if ({hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush} !== 4'b1111) begin
            errors++; $display("FAIL br_redirect: got %b want 1111", {hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush}); end
        tick();
        idle();
        set_load_use();
        hif.ex_branch_taken = 1'b1;
        #1;
        checks++; if (hif.state_o !== 2'd1) begin errors++; $display("FAIL br_state1: got %0d want 1", hif.state_o); end
        checks++; if ({hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush} !== 4'b1011) begin
            errors++; $display("FAIL br_flush1: got %b want 1011", {hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush}); end
        checks++; if (hif.flush_count !== 4'd1) begin errors++; $display("FAIL br_flush_count: got %0d want 1", hif.flush_count); end
        tick();
        #1;
        checks++; if (hif.state_o !== 2'd1 || hif.ifid_flush !== 1'b1) begin
            errors++; $display("FAIL br_cycle2: got state=%0d ifid_flush=%b want 1/1", hif.state_o, hif.ifid_flush); end
        tick();
        idle();
        #1;
        checks++; if (hif.state_o !== 2'd0 || hif.ifid_flush !== 1'b0) begin
            errors++; $display("FAIL br_cycle3: got state=%0d ifid_flush=%b want 0/0", hif.state_o, hif.ifid_flush); end
        checks++; if (hif.flush_count !== 4'd1 || hif.stall_count !== 4'd0) begin
            errors++; $display("FAIL br_counts: got %0d/%0d want 1/0", hif.flush_count, hif.stall_count); end
        tick();
    endtask

    task automatic test_mem_wait();
        clear_counts();
        hif.ex_branch_taken = 1'b1;
        hif.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.pc_redirect} !== 5'b00000) begin
                errors++; $display("FAIL mw_freeze%0d: got %b want 00000", i, {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.pc_redirect}); end
            if (i > 0) begin
                checks++; if (hif.state_o !== 2'd2) begin errors++; $display("FAIL mw_state%0d: got %0d want 2", i, hif.state_o); end
            end
            tick();
        end
        hif.mem_busy = 1'b0;
        #1;
        checks++; if (hif.state_o !== 2'd2) begin errors++; $display("FAIL mw_state_release: got %0d want 2", hif.state_o); end
        checks++; if ({hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush} !== 4'b1111) begin
            errors++; $display("FAIL mw_redirect: got %b want 1111", {hif.pc_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush}); end
        checks++; if (hif.stall_count !== 4'd4) begin errors++; $display("FAIL mw_stall_count: got %0d want 4", hif.stall_count); end
        tick();
        idle();
        #1;
        checks++; if (hif.state_o !== 2'd1 || hif.flush_count !== 4'd1) begin
            errors++; $display("FAIL mw_after: got state=%0d flush_count=%0d want 1/1", hif.state_o, hif.flush_count); end
        tick();
        tick();
        #1;
        checks++; if (hif.state_o !== 2'd0) begin errors++; $display("FAIL mw_drain: got %0d want 0", hif.state_o); end
    endtask

    task automatic test_simultaneous();
        clear_counts();
        hif.ex_branch_taken = 1'b1;
        set_load_use();
        hif.mem_busy = 1'b1;
        #1;
        checks++; if ({hif.pc_en, hif.ifid_en, hif.idex_en, hif.idex_flush, hif.ifid_flush} !== 5'b00000) begin
            errors++; $display("FAIL sim_freeze: got %b want 00000", {hif.pc_en, hif.ifid_en, hif.idex_en, hif.idex_flush, hif.ifid_flush}); end
        tick();
        tick();
        hif.mem_busy = 1'b0;
        #1;
        checks++; if ({hif.pc_en, hif.ifid_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush} !== 5'b11111) begin
            errors++; $display("FAIL sim_release: got %b want 11111", {hif.pc_en, hif.ifid_en, hif.pc_redirect, hif.ifid_flush, hif.idex_flush}); end
        tick();
        idle();
        #1;
        checks++; if (hif.stall_count !== 4'd2 || hif.flush_count !== 4'd1) begin
            errors++; $display("FAIL sim_counts: got %0d/%0d want 2/1", hif.stall_count, hif.flush_count); end
        tick();
        tick();
    endtask

    task automatic test_flush_mem_busy();
        hif.ex_branch_taken = 1'b1;
        tick();
        idle();
        hif.mem_busy = 1'b1;
        #1;
        checks++; if ({hif.pc_en, hif.ifid_flush, hif.idex_flush, hif.idex_en} !== 4'b0000 || hif.state_o !== 2'd1) begin
            errors++; $display("FAIL fmb_hold: got %b state=%0d want 0000 state=1", {hif.pc_en, hif.ifid_flush, hif.idex_flush, hif.idex_en}, hif.state_o); end
        tick();
        hif.mem_busy = 1'b0;
        tick();
        #1;
        checks++; if (hif.state_o !== 2'd1 || hif.ifid_flush !== 1'b1) begin
            errors++; $display("FAIL fmb_cnt_held: got state=%0d ifid_flush=%b want 1/1", hif.state_o, hif.ifid_flush); end
        tick();
        #1;
        checks++; if (hif.state_o !== 2'd0) begin errors++; $display("FAIL fmb_exit: got %0d want 0", hif.state_o); end
    endtask

    task automatic test_reset_mid_flush();
        hif.ex_branch_taken = 1'b1;
        tick();
        idle();
        rstn = 1'b0;
        #1;
        checks++; if ({hif.pc_en, hif.ifid_flush, hif.idex_flush} !== 3'b000 || hif.state_o !== 2'd0) begin
            errors++; $display("FAIL rmf_during: got %b state=%0d want 000 state=0", {hif.pc_en, hif.ifid_flush, hif.idex_flush}, hif.state_o); end
        tick();
        rstn = 1'b1;
        #1;
        checks++; if (hif.state_o !== 2'd0 || hif.stall_count !== 4'd0 || hif.flush_count !== 4'd0) begin
            errors++; $display("FAIL rmf_after: got state=%0d counts=%0d/%0d want 0 0/0", hif.state_o, hif.stall_count, hif.flush_count); end
        checks++; if ({hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.ifid_flush, hif.idex_flush} !== 6'b111100) begin
            errors++; $display("FAIL rmf_default: got %b want 111100", {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.ifid_flush, hif.idex_flush}); end
        tick();
        #1;
        checks++; if (hif.state_o !== 2'd0 || hif.ifid_flush !== 1'b0) begin
            errors++; $display("FAIL rmf_residue: got state=%0d ifid_flush=%b want 0/0", hif.state_o, hif.ifid_flush); end
    endtask

    task automatic test_saturation();
        clear_counts();
        set_load_use();
        for (int i = 0; i < 20; i++) tick();
        checks++; if (hif.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall: got %0d want 15", hif.stall_count); end
        hif.clr_counts = 1'b1;
        tick();
        checks++; if (hif.stall_count !== 4'd0) begin errors++; $display("FAIL sat_clr_priority: got %0d want 0", hif.stall_count); end
        hif.clr_counts = 1'b0;
        tick();
        checks++; if (hif.stall_count !== 4'd1) begin errors++; $display("FAIL sat_restart: got %0d want 1", hif.stall_count); end
        idle();
        clear_counts();
        for (int i = 0; i < 17; i++) begin
            hif.ex_branch_taken = 1'b1;
            tick();
            hif.ex_branch_taken = 1'b0;
            tick();
            tick();
        end
        checks++; if (hif.flush_count !== 4'd15 || hif.stall_count !== 4'd0) begin
            errors++; $display("FAIL sat_flush: got %0d/%0d want 15/0", hif.flush_count, hif.stall_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_simultaneous();
        test_flush_mem_busy();
        test_reset_mid_flush();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. It watches the ID-stage source registers, the ID/EX register contents (rdn, branch_taken, load flag) and the memory-stage busy flag. Each cycle it drives the enables and flushes for PC, IF/ID, ID/EX and EX/MEM. It resolves load-use hazards, taken-branch redirects with a configurable fetch-refill penalty, and multicycle memory stalls. It also keeps saturating stall and flush performance counters.

Parameters:
FlushCycles, 1, total cycles that IF/ID and ID/EX are flushed per taken branch (>=1; the redirect cycle counts as the first)
CntWidth, 32, width of stall_count and flush_count

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset, synchronous, active-low
id_rs1n  in  5  rs1 index of instruction in ID
id_rs2n  in  5  rs2 index of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rdn  in  5  destination index held in ID/EX
ex_is_load  in  1  ID/EX holds a load
ex_branch_taken  in  1  ID/EX branch_taken output (branch resolved taken)
mem_busy  in  1  data memory cannot complete this cycle
clr_counts  in  1  synchronous clear of both counters
pc_en  out  1  PC register update enable
pc_redirect  out  1  PC loads ID/EX branch_addr instead of PC+4
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble (rdn=0, branch_taken=0, a=b=0)
exmem_en  out  1  EX/MEM load enable
state_o  out  2  current FSM state (0 RUN, 1 FLUSH, 2 MEM_WAIT)
stall_count  out  CntWidth  cycles with pc_en=0 since reset/clear
flush_count  out  CntWidth  taken-branch redirects since reset/clear

Behaviour:
- Control outputs are combinational from state and current inputs (same-cycle action). FSM, flush counter and perf counters are registered.
- While rstn=0: all enables 0, flushes 0, pc_redirect 0, state_o 0. On the next edge: state=RUN, flush counter=0, both counts=0. Reset mid-FLUSH or mid-MEM_WAIT aborts to RUN with no residue.
- Default (no event): all enables 1, flushes 0, pc_redirect 0.
- Hazard detect: load_use = ex_is_load & ex_rdn!=0 & ((id_uses_rs1 & id_rs1n==ex_rdn) | (id_uses_rs2 & id_rs2n==ex_rdn)). Register x0 never hazards.
- Priority each cycle: mem_busy > branch redirect > load_use.
- RUN:
  - mem_busy=1: pc_en=ifid_en=idex_en=exmem_en=0; next state MEM_WAIT.
  - else ex_branch_taken=1: pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1, flush_count+1. If FlushCycles>1, go to FLUSH with cnt=FlushCycles-2; else stay RUN. Any coincident load_use is ignored because the instruction is wrong-path.
  - else load_use=1: pc_en=0, ifid_en=0, idex_flush=1 (one bubble); stay RUN. The hazard clears naturally next cycle.
- FLUSH: pc_en=1, ifid_flush=1, idex_flush=1, pc_redirect=0. ex_branch_taken and load_use are ignored.
  - If mem_busy=1: all enables 0, flushes 0, cnt held, stay FLUSH.
  - Else if cnt==0: go to RUN; else cnt-1.
- MEM_WAIT: same freeze as RUN+mem_busy while mem_busy=1. When mem_busy=0, outputs are evaluated exactly as in RUN (branch or load-use is acted on this cycle) and the state is left per the RUN rules. A branch held in ID/EX during the wait is therefore taken on the first free cycle.
- stall_count increments on every clocked cycle (rstn=1) with pc_en=0. It saturates at all-ones.
- flush_count increments per redirect and saturates.
- clr_counts=1 zeroes both counts and has priority over increment in the same cycle.
- Invariant: ifid_flush and ifid_en are never both 1 with pc_en=0. idex_flush is never 1 while idex_en=0.

Test Plan:
- Load-use: ex_is_load=1, ex_rdn=5, id_rs2n=5, id_uses_rs2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count=1. Repeat with ex_rdn=0 -> no stall.
- Branch, FlushCycles=3: ex_branch_taken=1 in RUN -> cycle 0 pc_redirect=1 and flushes=1; cycles 1-2 state_o=1 with flushes=1; cycle 3 RUN; flush_count=1.
- mem_busy held 4 cycles while ID/EX holds a taken branch -> all enables 0 for 4 cycles, state_o=2, stall_count=4; on release, pc_redirect=1 in that same cycle.
- Simultaneous branch + load_use + mem_busy -> freeze only; after release, redirect occurs and no load-use bubble is inserted.
- Reset mid-FLUSH (rstn=0 one cycle at cnt=1) -> state_o=0, counts=0, default enables after release.
- Saturation: CntWidth=4, 20 stall cycles -> stall_count=15. clr_counts with a concurrent stall -> 0.
